uart_tx: RTL and testbench

- UART transmitter that takes bytes written by the CPU core and serializes them onto the TX pin.
- Inputs come from the core's TXREG path: a one-cycle tx_req strobe plus the registered tx_data byte.
- A small FIFO buffers writes, so back-to-back MOVWF-to-TXREG writes are not lost while a frame is on the line.
- Frame format: 8N1, LSB first; the line idles high.

---
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to append an even parity bit (8E1 framing).
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, bit_end, pop, push, req_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
    // fullness is judged on the pre-pop count, so a write racing a pop on a full FIFO is dropped
    assign push      = req_d && (count != (AW+1)'(FIFO_DEPTH));
    assign pop       = (count != '0) && (state == IDLE || (state == STOP && bit_end));
    assign fifo_full = count == (AW+1)'(FIFO_DEPTH);
    assign tx_busy   = (state != IDLE) || (count != '0);
    assign tx_done   = (state == STOP) && bit_end;

    always_comb begin
        state_n   = state;
        cnt_n     = bit_end ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
`ifdef UART_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: cnt_n = '0;
            START: if (bit_end) begin
                tx_n      = shift[0];
                bit_idx_n = '0;
                state_n   = DATA;
            end
            DATA: if (bit_end) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    tx_n    = par;
                    state_n = PARITY;
`else
                    tx_n    = 1'b1;
                    state_n = STOP;
`endif
                end else begin
                    shift_n   = shift >> 1;
                    tx_n      = shift[1];
                    bit_idx_n = bit_idx + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                tx_n    = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // a pop from IDLE or the last stop cycle starts the next frame with no gap
        if (pop) begin
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            cnt_n   = '0;
            state_n = START;
`ifdef UART_TX_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            req_d    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
            req_d    <= tx_req;
            overflow <= req_d && !push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-position model.
module tb_uart_tx;
    localparam int N     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * N;

    logic       clk, rst, tx_req;
    logic [7:0] tx_data;
    logic       tx, tx_busy, fifo_full, overflow, tx_done;

    uart_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_req(tx_req), .tx_data(tx_data),
        .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full),
        .overflow(overflow), .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    // model: accepted bytes in a queue, the frame on the line as a cycle position
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int   pos = -1;
    logic m_req_d = 1'b0;
    logic m_ovf = 1'b0;
    logic m_pop, m_push;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            pos = -1;
            m_req_d = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_pop  = q.size() > 0 && (pos < 0 || pos == FL - 1);
            m_push = m_req_d && q.size() < DEPTH;
            m_ovf  = m_req_d && !m_push;
            if (m_pop) begin
                cur = q.pop_front();
                pos = 0;
            end else if (pos >= 0) begin
                pos = (pos == FL - 1) ? -1 : pos + 1;
            end
            if (m_push) q.push_back(tx_data);
            m_req_d = tx_req;
        end
    end

    function automatic logic exp_tx();
        int b;
        if (pos < 0) return 1'b1;
        b = pos / N;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("tx", tx, exp_tx());
            chk("tx_busy", tx_busy, pos >= 0 || q.size() > 0);
            chk("fifo_full", fifo_full, q.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("tx_done", tx_done, pos == FL - 1);
        end
    end

    task automatic write(input logic [7:0] b);
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        tx_data = b;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 8 * FL && tx_busy; i++) @(negedge clk);
        chk("idle_timeout", tx_busy, 1'b0);
    endtask

    // p[i] is the literal line level during frame bit i
    task automatic frame_check(input logic [7:0] b, input logic [10:0] p);
        write(b);
        chk("lat_tx_high", tx, 1'b1);
        chk("lat_busy", tx_busy, 1'b1);
        @(negedge clk);
        for (int k = 0; k < FL; k++) begin
            chk("frame_tx", tx, p[k / N]);
            chk("frame_done", tx_done, k == FL - 1);
            @(negedge clk);
        end
        chk("end_busy", tx_busy, 1'b0);
        chk("end_tx", tx, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        tx_req = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        frame_check(8'h55, 11'b10_01010101_0);
        frame_check(8'h07, 11'b11_00000111_0);
        frame_check(8'h03, 11'b10_00000011_0);
`else
        frame_check(8'h55, 11'b0_1_01010101_0);
        frame_check(8'h07, 11'b0_1_00000111_0);
        frame_check(8'h03, 11'b0_1_00000011_0);
`endif

        // reset during data bit 3 with two bytes queued
        write(8'hA5);
        @(negedge clk);
        chk("t4_fall", tx, 1'b0);
        write(8'h3C);
        write(8'hFF);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_tx", tx, 1'b1);
        chk("t4_rst_busy", tx_busy, 1'b0);
        chk("t4_rst_full", fifo_full, 1'b0);
        for (int i = 0; i < 12 * N; i++) begin
            chk("t4_quiet_tx", tx, 1'b1);
            chk("t4_no_done", tx_done, 1'b0);
            @(negedge clk);
        end

        // continuous writes: FIFO fills, then a write collides with the stop-bit pop
        tx_req = 1'b1;
        for (int i = 0; i < FL + 20 && !tx_done; i++) begin
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        chk("t6_done_seen", tx_done, 1'b1);
        tx_data = 8'($urandom);
        @(negedge clk);
        chk("t6_ovf_on_pop", overflow, 1'b1);
        chk("t6_not_full", fifo_full, 1'b0);
        tx_data = 8'($urandom);
        @(negedge clk);
        chk("t6_refill_full", fifo_full, 1'b1);
        chk("t6_refill_ovf", overflow, 1'b0);
        tx_req = 1'b0;
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            tx_req = $urandom_range(0, 11) == 0;
            tx_data = 8'($urandom);
            rst = $urandom_range(0, 799) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        tx_req = 1'b0;
        @(negedge clk);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
